// File: rtl/ulpi_phy_resp_pkg.sv
// ---------------------------------------------------------------------------
// ulpi_phy_resp_pkg
// Shared definitions for the PHY-side ULPI responder:
//   - FSM state enumeration
//   - TX CMD codes carried in bus bits [7:6]
//   - immediate register addresses, register-file indexing and reset values
// ---------------------------------------------------------------------------
package ulpi_phy_resp_pkg;

   typedef enum logic [3:0] {
      ULPI_PHY_STATE_STARTUP,
      ULPI_PHY_STATE_IDLE,
      ULPI_PHY_STATE_WR_CMD,
      ULPI_PHY_STATE_WR_DATA,
      ULPI_PHY_STATE_WR_STP,
      ULPI_PHY_STATE_RD_CMD,
      ULPI_PHY_STATE_RD_TURN,
      ULPI_PHY_STATE_RD_DATA,
      ULPI_PHY_STATE_TX,
      ULPI_PHY_STATE_RX_TURN,
      ULPI_PHY_STATE_RX_DATA,
      ULPI_PHY_STATE_TURN_BACK
   } ulpi_phy_state_t;

   // TX CMD code in i_data[7:6]
   localparam logic [1:0] TXCMD_NONE = 2'b00;
   localparam logic [1:0] TXCMD_XMIT = 2'b01;
   localparam logic [1:0] TXCMD_REGW = 2'b10;
   localparam logic [1:0] TXCMD_REGR = 2'b11;

   // Register addresses
   localparam logic [5:0] ADDR_VID_LO     = 6'h00;
   localparam logic [5:0] ADDR_VID_HI     = 6'h01;
   localparam logic [5:0] ADDR_PID_LO     = 6'h02;
   localparam logic [5:0] ADDR_PID_HI     = 6'h03;
   localparam logic [5:0] ADDR_FUNC_CTRL  = 6'h04;
   localparam logic [5:0] ADDR_IFACE_CTRL = 6'h07;
   localparam logic [5:0] ADDR_OTG_CTRL   = 6'h0A;
   localparam logic [5:0] ADDR_RISE_IE    = 6'h0D;
   localparam logic [5:0] ADDR_FALL_IE    = 6'h10;
   localparam logic [5:0] ADDR_SCRATCH    = 6'h16;
   localparam logic [5:0] ADDR_EXT        = 6'h2F;

   // Writable registers, each occupying base / base+1 (OR) / base+2 (AND-NOT)
   localparam int NUM_REGS     = 6;
   localparam int FUNC_IDX     = 0;
   localparam int SOFT_RST_BIT = 5;

   function automatic logic [5:0] reg_base(input int idx);
      case (idx)
         0:       return ADDR_FUNC_CTRL;
         1:       return ADDR_IFACE_CTRL;
         2:       return ADDR_OTG_CTRL;
         3:       return ADDR_RISE_IE;
         4:       return ADDR_FALL_IE;
         default: return ADDR_SCRATCH;
      endcase
   endfunction

   function automatic logic [7:0] reg_reset(input int idx);
      case (idx)
         0:       return 8'h41;
         1:       return 8'h00;
         2:       return 8'h06;
         3:       return 8'h1F;
         4:       return 8'h1F;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/ulpi_phy_regs.sv
// ---------------------------------------------------------------------------
// ulpi_phy_regs
// ULPI immediate register file with set/clear aliases and read-only IDs.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : commit pulse for the write of wdata to addr
//   addr       : 6-bit immediate register address
//   wdata      : write data
//   rdata      : combinational read of addr (aliases read the base value)
//   soft_rst   : high during the commit cycle of a write that leaves
//                func ctrl bit5 set; the PHY FSM restarts on that edge
// ---------------------------------------------------------------------------
module ulpi_phy_regs
   import ulpi_phy_resp_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID  = 16'h0424,
   parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [5:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       soft_rst
);

   logic [7:0] regs     [NUM_REGS];
   logic [7:0] regs_nxt [NUM_REGS];

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_nxt[i] = regs[i];
         if (wr_en) begin
            if (addr == reg_base(i))
               regs_nxt[i] = wdata;
            else if (addr == reg_base(i) + 6'd1)
               regs_nxt[i] = regs[i] | wdata;
            else if (addr == reg_base(i) + 6'd2)
               regs_nxt[i] = regs[i] & ~wdata;
         end
      end
   end

   // Soft reset is decided from the post-write value so the FSM can react
   // on the very edge that commits the write.
   assign soft_rst = wr_en & regs_nxt[FUNC_IDX][SOFT_RST_BIT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= reg_reset(i);
      end else if (soft_rst) begin
         // func ctrl keeps the written value with the reset bit self-cleared
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i == FUNC_IDX)
               regs[i] <= regs_nxt[i] & ~(8'h01 << SOFT_RST_BIT);
            else
               regs[i] <= reg_reset(i);
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= regs_nxt[i];
      end
   end

   always_comb begin
      rdata = 8'h00;
      case (addr)
         ADDR_VID_LO: rdata = VENDOR_ID[7:0];
         ADDR_VID_HI: rdata = VENDOR_ID[15:8];
         ADDR_PID_LO: rdata = PRODUCT_ID[7:0];
         ADDR_PID_HI: rdata = PRODUCT_ID[15:8];
         default: begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (addr >= reg_base(i) && addr <= reg_base(i) + 6'd2)
                  rdata = regs[i];
            end
         end
      endcase
   end

endmodule

// File: rtl/ulpi_phy_resp.sv
// ---------------------------------------------------------------------------
// ulpi_phy_resp
// PHY-side ULPI responder used as a closed-loop partner for a ULPI link.
// Runs the post-reset startup with dir held high, answers register
// write/read and transmit TX CMDs, and sends RX CMD bytes on line-state
// changes.
//   i_clk, i_rst_n : 60 MHz clock, asynchronous active-low reset
//   i_stp, i_data  : stp and bus value from the link
//   o_dir, o_nxt   : bus direction (1 = PHY drives) and nxt
//   o_data, o_data_oe : PHY bus value and its output enable
//   i_line_state   : {D-,D+}
//   o_tx_cnt       : bytes sunk in the last transmit packet
// ---------------------------------------------------------------------------
module ulpi_phy_resp
   import ulpi_phy_resp_pkg::*;
#(
   parameter logic [15:0] VENDOR_ID      = 16'h0424,
   parameter logic [15:0] PRODUCT_ID     = 16'h0009,
   parameter int unsigned STARTUP_CYCLES = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stp,
   input  logic [7:0]  i_data,
   output logic        o_dir,
   output logic        o_nxt,
   output logic [7:0]  o_data,
   output logic        o_data_oe,
   input  logic [1:0]  i_line_state,
   output logic [15:0] o_tx_cnt
);

   localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYCLES - 1);

   ulpi_phy_state_t state;
   logic [15:0]     startup_cnt;
   logic [15:0]     tx_acc;
   logic            wr_late;
   logic [1:0]      last_ls;
   logic            ls_valid;
   logic [5:0]      addr_q;
   logic [7:0]      wdata_q;
   logic [7:0]      rdata;
   logic            soft_rst;
   logic            wr_en;

   // A write commits only when stp arrives on the first WR_STP edge.
   assign wr_en = (state == ULPI_PHY_STATE_WR_STP) && i_stp && !wr_late;

   ulpi_phy_regs #(
      .VENDOR_ID  (VENDOR_ID),
      .PRODUCT_ID (PRODUCT_ID)
   ) u_regs (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .wr_en    (wr_en),
      .addr     (addr_q),
      .wdata    (wdata_q),
      .rdata    (rdata),
      .soft_rst (soft_rst)
   );

   // Command address and write data capture (no reset needed)
   always_ff @(posedge i_clk) begin
      if (state == ULPI_PHY_STATE_IDLE)
         addr_q <= i_data[5:0];
      if (state == ULPI_PHY_STATE_WR_DATA)
         wdata_q <= i_data;
   end

   // Bus FSM with registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ULPI_PHY_STATE_STARTUP;
         o_dir       <= 1'b1;
         o_nxt       <= 1'b0;
         o_data      <= 8'h00;
         o_data_oe   <= 1'b0;
         o_tx_cnt    <= 16'h0000;
         startup_cnt <= 16'h0000;
         tx_acc      <= 16'h0000;
         wr_late     <= 1'b0;
         last_ls     <= 2'b00;
         ls_valid    <= 1'b0;
      end else begin
         // Reference line state is taken on the first edge after release.
         if (!ls_valid) begin
            last_ls  <= i_line_state;
            ls_valid <= 1'b1;
         end

         case (state)
            ULPI_PHY_STATE_STARTUP: begin
               o_nxt     <= 1'b0;
               o_data_oe <= 1'b0;
               if (startup_cnt == STARTUP_LAST) begin
                  o_dir       <= 1'b0;
                  startup_cnt <= 16'h0000;
                  state       <= ULPI_PHY_STATE_TURN_BACK;
               end else begin
                  o_dir       <= 1'b1;
                  startup_cnt <= startup_cnt + 16'd1;
               end
            end

            ULPI_PHY_STATE_TURN_BACK: begin
               o_dir     <= 1'b0;
               o_nxt     <= 1'b0;
               o_data_oe <= 1'b0;
               o_data    <= 8'h00;
               state     <= ULPI_PHY_STATE_IDLE;
            end

            ULPI_PHY_STATE_IDLE: begin
               o_dir     <= 1'b0;
               o_nxt     <= 1'b0;
               o_data_oe <= 1'b0;
               o_data    <= 8'h00;
               case (i_data[7:6])
                  TXCMD_REGW: begin
                     if (i_data[5:0] != ADDR_EXT) begin
                        o_nxt <= 1'b1;
                        state <= ULPI_PHY_STATE_WR_CMD;
                     end
                  end
                  TXCMD_REGR: begin
                     if (i_data[5:0] != ADDR_EXT) begin
                        o_nxt <= 1'b1;
                        state <= ULPI_PHY_STATE_RD_CMD;
                     end
                  end
                  TXCMD_XMIT: begin
                     o_nxt  <= 1'b1;
                     tx_acc <= 16'h0000;
                     state  <= ULPI_PHY_STATE_TX;
                  end
                  default: begin
                     // Link command outranks an RX CMD; report only on a quiet bus.
                     if (i_data == 8'h00 && ls_valid && i_line_state != last_ls) begin
                        o_dir <= 1'b1;
                        state <= ULPI_PHY_STATE_RX_TURN;
                     end
                  end
               endcase
            end

            ULPI_PHY_STATE_WR_CMD: begin
               o_nxt <= 1'b1;
               state <= ULPI_PHY_STATE_WR_DATA;
            end

            ULPI_PHY_STATE_WR_DATA: begin
               o_nxt   <= 1'b0;
               wr_late <= 1'b0;
               state   <= ULPI_PHY_STATE_WR_STP;
            end

            ULPI_PHY_STATE_WR_STP: begin
               if (i_stp) begin
                  wr_late <= 1'b0;
                  if (soft_rst) begin
                     o_dir       <= 1'b1;
                     startup_cnt <= 16'h0000;
                     state       <= ULPI_PHY_STATE_STARTUP;
                  end else begin
                     state <= ULPI_PHY_STATE_IDLE;
                  end
               end else begin
                  // Late stp: the write is abandoned once stp finally shows.
                  wr_late <= 1'b1;
               end
            end

            ULPI_PHY_STATE_RD_CMD: begin
               o_nxt     <= 1'b0;
               o_dir     <= 1'b1;
               o_data_oe <= 1'b0;
               state     <= ULPI_PHY_STATE_RD_TURN;
            end

            ULPI_PHY_STATE_RD_TURN: begin
               o_data_oe <= 1'b1;
               o_data    <= rdata;
               state     <= ULPI_PHY_STATE_RD_DATA;
            end

            ULPI_PHY_STATE_RD_DATA: begin
               o_dir     <= 1'b0;
               o_data_oe <= 1'b0;
               o_data    <= 8'h00;
               state     <= ULPI_PHY_STATE_TURN_BACK;
            end

            ULPI_PHY_STATE_TX: begin
               if (i_stp) begin
                  o_tx_cnt <= tx_acc;
                  o_nxt    <= 1'b0;
                  state    <= ULPI_PHY_STATE_IDLE;
               end else if (tx_acc != 16'hFFFF) begin
                  tx_acc <= tx_acc + 16'd1;
               end
            end

            ULPI_PHY_STATE_RX_TURN: begin
               o_data_oe <= 1'b1;
               o_data    <= {6'b000000, i_line_state};
               last_ls   <= i_line_state;
               state     <= ULPI_PHY_STATE_RX_DATA;
            end

            ULPI_PHY_STATE_RX_DATA: begin
               o_dir     <= 1'b0;
               o_data_oe <= 1'b0;
               o_data    <= 8'h00;
               state     <= ULPI_PHY_STATE_TURN_BACK;
            end

            default: state <= ULPI_PHY_STATE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ulpi_phy_resp.sv
// ---------------------------------------------------------------------------
// tb_ulpi_phy_resp
// Directed bench for the PHY responder: a table of register write/read
// vectors plus hand-written sequences for startup, soft reset, late stp,
// extended address, transmit counting, RX CMDs and async reset mid-write.
// ---------------------------------------------------------------------------
module tb_ulpi_phy_resp;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        stp     = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [1:0]  ls      = 2'b00;
   logic        dir;
   logic        nxt;
   logic        oe;
   logic [7:0]  data_out;
   logic [15:0] tx_cnt;

   int checks   = 0;
   int failures = 0;

   ulpi_phy_resp #(
      .VENDOR_ID      (16'h0424),
      .PRODUCT_ID     (16'h0009),
      .STARTUP_CYCLES (8)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_stp        (stp),
      .i_data       (data_in),
      .o_dir        (dir),
      .o_nxt        (nxt),
      .o_data       (data_out),
      .o_data_oe    (oe),
      .i_line_state (ls),
      .o_tx_cnt     (tx_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] wcmd;   // 0 = no write before the read
      logic [7:0] wdat;
      logic [7:0] rcmd;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [17];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // dir high for 7 more edges, low after the 8th, then TURN_BACK -> IDLE
   task automatic startup_seq(input string name);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk($sformatf("%s_dir%0d", name, k), dir, (k < 8) ? 1'b1 : 1'b0);
         chk($sformatf("%s_nxt%0d", name, k), nxt, 1'b0);
         chk($sformatf("%s_oe%0d", name, k), oe, 1'b0);
      end
      tick();
   endtask

   task automatic do_write(input logic [7:0] cmd, input logic [7:0] dat);
      data_in = cmd;
      tick();
      chk("wr_nxt_c1", nxt, 1'b1);
      data_in = 8'h00;
      tick();
      chk("wr_nxt_c2", nxt, 1'b1);
      data_in = dat;
      tick();
      chk("wr_nxt_c3", nxt, 1'b0);
      data_in = 8'h00;
      stp = 1'b1;
      tick();
      chk("wr_nxt_c4", nxt, 1'b0);
      stp = 1'b0;
   endtask

   task automatic do_read(input logic [7:0] cmd, output logic [7:0] dat);
      data_in = cmd;
      tick();
      chk("rd_nxt_c1", nxt, 1'b1);
      chk("rd_dir_c1", dir, 1'b0);
      data_in = 8'h00;
      tick();
      chk("rd_nxt_c2", nxt, 1'b0);
      chk("rd_dir_c2", dir, 1'b1);
      chk("rd_oe_c2", oe, 1'b0);
      tick();
      chk("rd_dir_c3", dir, 1'b1);
      chk("rd_oe_c3", oe, 1'b1);
      dat = data_out;
      tick();
      chk("rd_dir_c4", dir, 1'b0);
      chk("rd_oe_c4", oe, 1'b0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rd;

      vecs[0]  = '{8'h96, 8'hA5, 8'hD6, 8'hA5};  // scratch load
      vecs[1]  = '{8'h98, 8'h05, 8'hD6, 8'hA0};  // scratch clear alias
      vecs[2]  = '{8'h00, 8'h00, 8'hD7, 8'hA0};  // read via set alias
      vecs[3]  = '{8'h00, 8'h00, 8'hC0, 8'h24};
      vecs[4]  = '{8'h00, 8'h00, 8'hC1, 8'h04};
      vecs[5]  = '{8'h00, 8'h00, 8'hC2, 8'h09};
      vecs[6]  = '{8'h00, 8'h00, 8'hC3, 8'h00};
      vecs[7]  = '{8'h80, 8'hFF, 8'hC0, 8'h24};  // ID write ignored
      vecs[8]  = '{8'h97, 8'h0F, 8'hD8, 8'hAF};  // scratch set alias
      vecs[9]  = '{8'h00, 8'h00, 8'hCA, 8'h06};  // OTG reset value
      vecs[10] = '{8'h8E, 8'h20, 8'hCD, 8'h3F};  // rise IE set
      vecs[11] = '{8'h91, 8'h80, 8'hD2, 8'h9F};  // fall IE set
      vecs[12] = '{8'h87, 8'h5A, 8'hC7, 8'h5A};  // iface load
      vecs[13] = '{8'h89, 8'h0A, 8'hC8, 8'h50};  // iface clear
      vecs[14] = '{8'hA0, 8'h33, 8'hE0, 8'h00};  // unmapped address
      vecs[15] = '{8'h00, 8'h00, 8'hC5, 8'h41};  // func ctrl reset value
      vecs[16] = '{8'h86, 8'h01, 8'hC4, 8'h40};  // func clear, no soft reset

      // Reset state
      tick();
      tick();
      chk("rst_dir", dir, 1'b1);
      chk("rst_nxt", nxt, 1'b0);
      chk("rst_oe", oe, 1'b0);
      chk("rst_data", data_out, 8'h00);
      chk("rst_txcnt", tx_cnt, 16'h0000);
      rst_n = 1'b1;
      startup_seq("startup");

      // Register vectors
      for (int i = 0; i < 17; i++) begin
         if (vecs[i].wcmd != 8'h00)
            do_write(vecs[i].wcmd, vecs[i].wdat);
         do_read(vecs[i].rcmd, rd);
         chk($sformatf("vec%0d", i), rd, vecs[i].exp);
      end

      // Late stp: write abandoned
      data_in = 8'h96;
      tick();
      data_in = 8'h00;
      tick();
      data_in = 8'h11;
      tick();
      data_in = 8'h00;
      tick();
      chk("late_nxt_e4", nxt, 1'b0);
      tick();
      stp = 1'b1;
      tick();
      stp = 1'b0;
      chk("late_dir", dir, 1'b0);
      do_read(8'hD6, rd);
      chk("late_no_commit", rd, 8'hAF);

      // Extended address: no nxt, stays idle
      data_in = 8'hAF;
      tick();
      chk("ext_wr_nxt", nxt, 1'b0);
      data_in = 8'hEF;
      tick();
      chk("ext_rd_nxt", nxt, 1'b0);
      chk("ext_rd_dir", dir, 1'b0);
      data_in = 8'h00;
      tick();
      chk("ext_idle_dir", dir, 1'b0);

      // Soft reset through func ctrl
      do_write(8'h84, 8'h61);
      chk("srst_dir_c4", dir, 1'b1);
      startup_seq("srst");
      do_read(8'hC4, rd);
      chk("srst_func", rd, 8'h41);
      do_read(8'hCA, rd);
      chk("srst_otg", rd, 8'h06);
      do_read(8'hD6, rd);
      chk("srst_scratch", rd, 8'h00);
      do_read(8'hC7, rd);
      chk("srst_iface", rd, 8'h00);
      do_read(8'hCD, rd);
      chk("srst_rise", rd, 8'h1F);

      // Transmit packets of 3, 0 and 5 bytes
      for (int p = 0; p < 3; p++) begin
         int nbytes;
         nbytes = (p == 0) ? 3 : (p == 1) ? 0 : 5;
         data_in = 8'h40;
         tick();
         chk($sformatf("tx%0d_nxt_e1", p), nxt, 1'b1);
         data_in = 8'h5A;
         for (int b = 0; b < nbytes; b++) begin
            tick();
            chk($sformatf("tx%0d_nxt_b%0d", p, b), nxt, 1'b1);
         end
         stp = 1'b1;
         tick();
         stp = 1'b0;
         data_in = 8'h00;
         chk($sformatf("tx%0d_nxt_exit", p), nxt, 1'b0);
         chk($sformatf("tx%0d_cnt", p), tx_cnt, 16'(nbytes));
      end

      // RX CMD from idle
      ls = 2'b01;
      tick();
      chk("rx_turn_dir", dir, 1'b1);
      chk("rx_turn_oe", oe, 1'b0);
      tick();
      chk("rx_data_dir", dir, 1'b1);
      chk("rx_data_oe", oe, 1'b1);
      chk("rx_data", data_out, 8'h01);
      tick();
      chk("rx_back_dir", dir, 1'b0);
      chk("rx_back_oe", oe, 1'b0);
      tick();
      tick();
      chk("rx_no_repeat", dir, 1'b0);

      // Line-state change during a read: RX CMD after TURN_BACK
      data_in = 8'hD6;
      tick();
      data_in = 8'h00;
      ls = 2'b10;
      tick();
      chk("rdrx_dir_c2", dir, 1'b1);
      tick();
      chk("rdrx_oe_c3", oe, 1'b1);
      chk("rdrx_rdata", data_out, 8'h00);
      tick();
      chk("rdrx_dir_c4", dir, 1'b0);
      tick();
      chk("rdrx_dir_c5", dir, 1'b0);
      tick();
      chk("rdrx_dir_c6", dir, 1'b1);
      chk("rdrx_oe_c6", oe, 1'b0);
      tick();
      chk("rdrx_oe_c7", oe, 1'b1);
      chk("rdrx_data_c7", data_out, 8'h02);
      tick();
      chk("rdrx_dir_c8", dir, 1'b0);
      tick();

      // Async reset in the middle of a write
      do_write(8'h96, 8'h3C);
      do_read(8'hD6, rd);
      chk("pre_arst_scratch", rd, 8'h3C);
      data_in = 8'h96;
      tick();
      data_in = 8'h00;
      tick();
      data_in = 8'h77;
      tick();
      data_in = 8'h00;
      stp = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("arst_dir", dir, 1'b1);
      chk("arst_nxt", nxt, 1'b0);
      chk("arst_txcnt", tx_cnt, 16'h0000);
      tick();
      stp = 1'b0;
      rst_n = 1'b1;
      startup_seq("arst");
      do_read(8'hD6, rd);
      chk("arst_scratch", rd, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ulpi_phy_resp.md
Name: ulpi_phy_resp

Overview:
PHY-side ULPI responder: the other end of the bus driven by ulpi_ctrl. Used as a simulation and prototype PHY model so the link controller can be exercised in closed loop.
- Runs the post-reset startup (dir held high), then answers link TX CMDs: register write, register read, packet transmit.
- Emits RX CMD bytes when line state changes.
- Owns a small ULPI immediate register file with set/clear aliases.

Parameters:
VENDOR_ID, 16'h0424, value returned at 0x00 (low byte) and 0x01 (high byte)
PRODUCT_ID, 16'h0009, value returned at 0x02 (low byte) and 0x03 (high byte)
STARTUP_CYCLES, 8, clock edges dir stays high after reset release or soft reset (>=1)

Ports:
i_clk  in  1  ULPI 60 MHz clock; all logic on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_stp  in  1  stp from link
i_data  in  8  bus value driven by link (valid when o_dir=0)
o_dir  out  1  bus direction; 1 = PHY owns bus
o_nxt  out  1  nxt to link
o_data  out  8  bus value driven by PHY
o_data_oe  out  1  PHY output enable on the data bus
i_line_state  in  2  current line state {D-,D+}
o_tx_cnt  out  16  bytes sunk in the last transmit packet

Behaviour:
- Reset (async, i_rst_n=0): o_dir=1, o_nxt=0, o_data=0, o_data_oe=0, o_tx_cnt=0, state STARTUP, registers at reset values, last_ls=i_line_state sampled on release.
- All outputs are registered. E1 is the edge that samples a TX CMD; cycle k follows edge Ek.
- STARTUP: dir=1 for STARTUP_CYCLES edges after release, then dir=0 -> TURN_BACK.
- TURN_BACK: one cycle with dir=0 and oe=0; i_data is ignored; then IDLE.
- IDLE: i_data[7:6] selects the command.
  - 00: no command.
  - 10: write; addr = i_data[5:0].
  - 11: read; addr = i_data[5:0].
  - 01: transmit.
  - Link command has priority over a pending line-state change.
- Write:
  - E1: state WR_CMD, nxt=1.
  - E2: WR_DATA, nxt=1.
  - E3: latch i_data as wdata, go to WR_STP, nxt=0.
  - E4: if i_stp=1, commit the write and go to IDLE. If i_stp=0, stay in WR_STP with no commit until stp is seen, then go to IDLE with no commit.
- Read:
  - E1: RD_CMD, nxt=1.
  - E2: RD_TURN, nxt=0, dir=1, oe=0.
  - E3: RD_DATA, oe=1, o_data=reg[addr].
  - E4: TURN_BACK, dir=0, oe=0.
- Extended address (addr 6'h2F): unsupported. No nxt is asserted and the PHY stays in IDLE.
- Transmit:
  - E1: TX, nxt=1, counter cleared.
  - Each edge in TX with i_stp=0 counts one byte (16-bit, saturating at 16'hFFFF).
  - Edge with i_stp=1: o_tx_cnt=counter, nxt=0, go to IDLE.
- RX CMD: in IDLE with i_data==0 and i_line_state!=last_ls:
  - RX_TURN: dir=1, oe=0.
  - RX_DATA: oe=1, o_data={6'b0, ls}; last_ls updated.
  - TURN_BACK.
  - A change during a command is reported when the FSM next reaches IDLE.
- Register map:
  - 0x00-0x03: read-only IDs; writes ignored.
  - Base registers with reset values: 0x04 func ctrl=0x41, 0x07 iface ctrl=0x00, 0x0A OTG ctrl=0x06, 0x0D rise IE=0x1F, 0x10 fall IE=0x1F, 0x16 scratch=0x00.
  - For each base B: write B = load, B+1 = OR, B+2 = AND-NOT. Read of B, B+1 or B+2 returns the B value.
  - Any other address: read 0x00, write ignored.
- Soft reset: a committed write leaving func ctrl bit5=1 clears bit5 and resets all other registers. It then enters STARTUP (dir=1 for STARTUP_CYCLES) starting the cycle after commit.
- Async reset mid-transaction: immediate return to reset values. No partial write commits.

Decomposition:
- defs.svh: ulpi_phy_state_t enum (ULPI_PHY_STATE_STARTUP, _IDLE, _WR_CMD, _WR_DATA, _WR_STP, _RD_CMD, _RD_TURN, _RD_DATA, _TX, _RX_TURN, _RX_DATA, _TURN_BACK); TX CMD code constants; register address constants.
- Sub-module ulpi_phy_regs: register file, set/clear aliasing, ID decode, soft-reset detect. Ports: clk, rst_n, wr_en, addr, wdata, rdata, soft_rst pulse.

Test Plan:
- Reset then release with STARTUP_CYCLES=8 -> o_dir=1 for 8 edges, then 0; oe=0; nxt=0 throughout.
- Write 0x96 (0x16) then 0xA5, stp at E4; then read 0xD6 (0x16) -> nxt high in cycles 1-2; read returns o_data=0xA5 at cycle 3 with dir=1, oe=1; dir=0 at cycle 4.
- Write 0x98 (clear alias) 0x05 after scratch=0xA5 -> read 0x16 returns 0xA0. Read 0x00/0x01 -> 0x24/0x04.
- Write 0x84 (func ctrl) with 0x61 -> dir=1 for 8 cycles; then read 0x04 returns 0x41 and 0x0A returns 0x06.
- TX CMD 0x40, hold stp=0 for 5 edges, then stp=1 -> o_tx_cnt=5, nxt=0 at exit.
- i_line_state 00->01 while idle -> dir=1 turnaround, then o_data=0x01 with oe=1, then dir=0. Same change during a read -> RX CMD follows after TURN_BACK.
